// File: rtl/robot_nav_controller_if.sv
// ============================================================================
// Module      : robot_nav_controller_if
// Description : Sensor sample and motion-command handshake bundle between the
//               navigation controller and the world/robot datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface robot_nav_controller_if;
    logic       sensors_valid;
    logic       head;
    logic       left;
    logic       under;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;

    modport master (
        input  sensors_valid,
        input  head,
        input  left,
        input  under,
        input  cmd_ready,
        output cmd_valid,
        output cmd
    );

    modport slave (
        output sensors_valid,
        output head,
        output left,
        output under,
        output cmd_ready,
        input  cmd_valid,
        input  cmd
    );
endinterface

`default_nettype wire

// File: rtl/robot_nav_controller.sv
// ============================================================================
// Module      : robot_nav_controller
// Description : Left-hand wall-following navigation sequencer; issues one
//               motion command per sensor sample and tracks orientation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module robot_nav_controller #(
    parameter int MAX_TURNS = 4,
    parameter int CNT_W     = 8
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               start,
    robot_nav_controller_if.master  nav,
    output logic [1:0]              orientation,
    output logic                    following,
    output logic                    stuck,
    output logic [CNT_W-1:0]        removed_count
);

    localparam int TW = $clog2(MAX_TURNS + 1);

    localparam logic [1:0] c_cmd_forward    = 2'b00;
    localparam logic [1:0] c_cmd_turn_left  = 2'b01;
    localparam logic [1:0] c_cmd_turn_right = 2'b10;
    localparam logic [1:0] c_cmd_remove     = 2'b11;

    localparam logic [1:0] c_north = 2'b00;
    localparam logic [1:0] c_south = 2'b01;
    localparam logic [1:0] c_east  = 2'b10;
    localparam logic [1:0] c_west  = 2'b11;

    localparam logic [TW-1:0] c_max_turns = TW'(MAX_TURNS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SENS = 2'd1,
        S_ISSUE     = 2'd2,
        S_STUCK     = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_cmd_valid;
    logic [1:0]       r_cmd;
    logic [1:0]       r_orient;
    logic             r_following;
    logic             r_stuck;
    logic [CNT_W-1:0] r_removed;
    logic [TW-1:0]    r_turn_cnt;
    logic             r_just_turned_left;

    logic [1:0]       w_next_cmd;
    logic [1:0]       w_orient_left;
    logic [1:0]       w_orient_right;
    logic [TW-1:0]    w_turn_inc;
    logic             w_accept;

    // Wall-following decision on the live sensor inputs; only latched in WAIT_SENS.
    always_comb begin
        w_next_cmd = c_cmd_forward;
        if (nav.under) begin
            w_next_cmd = c_cmd_remove;
        end else if (!r_following) begin
            w_next_cmd = nav.head ? c_cmd_turn_right : c_cmd_forward;
        end else if (!nav.left && !r_just_turned_left) begin
            w_next_cmd = c_cmd_turn_left;
        end else begin
            w_next_cmd = nav.head ? c_cmd_turn_right : c_cmd_forward;
        end
    end

    always_comb begin
        w_orient_left  = c_north;
        w_orient_right = c_north;
        case (r_orient)
            c_north: begin w_orient_left = c_west;  w_orient_right = c_east;  end
            c_west:  begin w_orient_left = c_south; w_orient_right = c_north; end
            c_south: begin w_orient_left = c_east;  w_orient_right = c_west;  end
            default: begin w_orient_left = c_north; w_orient_right = c_south; end
        endcase
    end

    assign w_turn_inc = r_turn_cnt + TW'(1);
    assign w_accept   = r_cmd_valid && nav.cmd_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_cmd_valid        <= 1'b0;
            r_cmd              <= c_cmd_forward;
            r_orient           <= c_north;
            r_following        <= 1'b0;
            r_stuck            <= 1'b0;
            r_removed          <= '0;
            r_turn_cnt         <= '0;
            r_just_turned_left <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_valid <= 1'b0;
                    if (start) begin
                        r_state <= S_WAIT_SENS;
                    end
                end

                S_WAIT_SENS: begin
                    if (nav.sensors_valid) begin
                        r_cmd       <= w_next_cmd;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (w_accept) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT_SENS;
                        case (r_cmd)
                            c_cmd_forward: begin
                                r_turn_cnt         <= '0;
                                r_just_turned_left <= 1'b0;
                            end
                            c_cmd_turn_left: begin
                                r_orient           <= w_orient_left;
                                r_just_turned_left <= 1'b1;
                            end
                            c_cmd_turn_right: begin
                                r_orient    <= w_orient_right;
                                r_turn_cnt  <= w_turn_inc;
                                r_following <= 1'b1;
                                if (w_turn_inc == c_max_turns) begin
                                    r_state <= S_STUCK;
                                    r_stuck <= 1'b1;
                                end
                            end
                            default: begin
                                if (r_removed != {CNT_W{1'b1}}) begin
                                    r_removed <= r_removed + CNT_W'(1);
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    r_cmd_valid <= 1'b0;
                    r_stuck     <= 1'b1;
                end
            endcase
        end
    end

    assign nav.cmd_valid  = r_cmd_valid;
    assign nav.cmd        = r_cmd;
    assign orientation    = r_orient;
    assign following      = r_following;
    assign stuck          = r_stuck;
    assign removed_count  = r_removed;

endmodule

`default_nettype wire

// File: tb/tb_robot_nav_controller.sv
// ============================================================================
// Module      : tb_robot_nav_controller
// Description : Directed scoreboard bench for robot_nav_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_robot_nav_controller;

    localparam logic [1:0] FWD = 2'b00;
    localparam logic [1:0] TL  = 2'b01;
    localparam logic [1:0] TR  = 2'b10;
    localparam logic [1:0] REM = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] orientation;
    logic       following;
    logic       stuck;
    logic [1:0] removed_count;

    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    int         n_checks = 0;
    int         n_errors = 0;

    robot_nav_controller_if bus ();

    robot_nav_controller #(
        .MAX_TURNS (4),
        .CNT_W     (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .nav           (bus.master),
        .orientation   (orientation),
        .following     (following),
        .stuck         (stuck),
        .removed_count (removed_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every completed handshake must match the oldest expectation.
    always @(negedge clock) begin
        if (reset && bus.cmd_valid && bus.cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", 32'(bus.cmd), 32'hFFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cmd", 32'(bus.cmd), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (bus.cmd_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(bus.cmd_valid), 0);
    endtask

    task automatic issue(input logic h, input logic l, input logic u, input logic [1:0] exp);
        exp_q.push_back(exp);
        bus.head          = h;
        bus.left          = l;
        bus.under         = u;
        bus.sensors_valid = 1'b1;
        tick();
        bus.sensors_valid = 1'b0;
        check("valid_latency", 32'(bus.cmd_valid), 1);
        wait_accept();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sensors_valid = 1'b0;
        bus.head          = 1'b0;
        bus.left          = 1'b0;
        bus.under         = 1'b0;
        bus.cmd_ready     = 1'b1;

        repeat (3) tick();
        check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        check("rst_cmd", 32'(bus.cmd), 0);
        check("rst_orient", 32'(orientation), 0);
        check("rst_following", 32'(following), 0);
        check("rst_stuck", 32'(stuck), 0);
        check("rst_removed", 32'(removed_count), 0);

        reset = 1'b1;
        tick();
        do_start();

        // Straight-line motion before any wall is found.
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b0, 1'b0, FWD);
            check("fwd_orient", 32'(orientation), 0);
            check("fwd_following", 32'(following), 0);
        end

        // Wall acquisition, left turn, then suppressed second left turn.
        issue(1'b1, 1'b0, 1'b0, TR);
        check("acq_orient", 32'(orientation), 2);
        check("acq_following", 32'(following), 1);
        issue(1'b0, 1'b0, 1'b0, TL);
        check("tl_orient", 32'(orientation), 0);
        issue(1'b0, 1'b0, 1'b0, FWD);
        check("jtl_orient", 32'(orientation), 0);

        // Trash removal with saturation at 3.
        issue(1'b1, 1'b0, 1'b1, REM);
        check("rem_count1", 32'(removed_count), 1);
        check("rem_orient", 32'(orientation), 0);
        issue(1'b0, 1'b0, 1'b1, REM);
        check("rem_count2", 32'(removed_count), 2);
        issue(1'b0, 1'b1, 1'b1, REM);
        check("rem_count3", 32'(removed_count), 3);
        issue(1'b0, 1'b0, 1'b1, REM);
        check("rem_sat4", 32'(removed_count), 3);
        issue(1'b1, 1'b1, 1'b1, REM);
        check("rem_sat5", 32'(removed_count), 3);

        // Backpressure on a pending TURN_RIGHT, with a stray sensors_valid.
        bus.cmd_ready = 1'b0;
        exp_q.push_back(TR);
        bus.head = 1'b1; bus.left = 1'b1; bus.under = 1'b0;
        bus.sensors_valid = 1'b1;
        tick();
        bus.sensors_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.cmd_valid), 1);
            check("bp_cmd", 32'(bus.cmd), 32'(TR));
            check("bp_orient", 32'(orientation), 0);
            bus.sensors_valid = (i == 2);
            bus.under         = (i == 2);
            tick();
        end
        bus.sensors_valid = 1'b0;
        bus.under         = 1'b0;
        bus.cmd_ready     = 1'b1;
        tick();
        wait_accept();
        check("bp_orient_after", 32'(orientation), 2);
        check("bp_valid_after", 32'(bus.cmd_valid), 0);
        check("bp_single", 32'(exp_q.size()), 0);

        // Back to north, clear the turn counter, then four right turns -> stuck.
        issue(1'b0, 1'b0, 1'b0, TL);
        check("pre_orient", 32'(orientation), 0);
        issue(1'b0, 1'b0, 1'b0, FWD);
        issue(1'b1, 1'b1, 1'b0, TR);
        check("spin1_orient", 32'(orientation), 2);
        issue(1'b1, 1'b1, 1'b0, TR);
        check("spin2_orient", 32'(orientation), 1);
        issue(1'b1, 1'b1, 1'b0, TR);
        check("spin3_orient", 32'(orientation), 3);
        check("spin3_stuck", 32'(stuck), 0);
        issue(1'b1, 1'b1, 1'b0, TR);
        check("spin4_orient", 32'(orientation), 0);
        check("spin4_stuck", 32'(stuck), 1);

        bus.sensors_valid = 1'b1;
        start             = 1'b1;
        tick();
        bus.sensors_valid = 1'b0;
        start             = 1'b0;
        repeat (4) tick();
        check("stuck_valid", 32'(bus.cmd_valid), 0);
        check("stuck_flag", 32'(stuck), 1);
        check("stuck_orient", 32'(orientation), 0);

        // Asynchronous reset while a TURN_RIGHT is pending.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        do_start();
        bus.cmd_ready     = 1'b0;
        bus.head = 1'b1; bus.left = 1'b0; bus.under = 1'b0;
        bus.sensors_valid = 1'b1;
        tick();
        bus.sensors_valid = 1'b0;
        check("pend_valid", 32'(bus.cmd_valid), 1);
        check("pend_cmd", 32'(bus.cmd), 32'(TR));
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.cmd_valid), 0);
        check("arst_cmd", 32'(bus.cmd), 0);
        check("arst_orient", 32'(orientation), 0);
        check("arst_following", 32'(following), 0);
        check("arst_stuck", 32'(stuck), 0);
        check("arst_removed", 32'(removed_count), 0);
        tick();
        reset         = 1'b1;
        bus.cmd_ready = 1'b1;
        tick();
        do_start();
        issue(1'b1, 1'b0, 1'b0, TR);
        check("post_rst_orient", 32'(orientation), 2);
        check("post_rst_following", 32'(following), 1);

        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/robot_nav_controller.md
Name: robot_nav_controller

Overview:
- Navigation sequencer for the pipe-cleaning robot.
- Reads the robot's local sensors and decides one motion command per step with a left-hand wall-following rule.
- Issues each command to the world/robot datapath over a valid/ready handshake and tracks the robot's orientation.
- Sits between the sensor outputs of the world model and its command input; detects trash removal and stuck conditions.

Parameters:
MAX_TURNS, 4, consecutive TURN_RIGHT commands without an intervening FORWARD that declare the robot stuck
CNT_W, 8, width of the saturating trash-removal counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins navigation from IDLE
sensors_valid  input  1  head/left/under are fresh for the current robot position
head  input  1  1 = obstacle directly ahead
left  input  1  1 = wall on robot's left
under  input  1  1 = trash under robot
cmd_valid  output  1  command presented
cmd_ready  input  1  datapath accepts command this cycle
cmd  output  2  00 FORWARD, 01 TURN_LEFT, 10 TURN_RIGHT, 11 REMOVE
orientation  output  2  00 north, 01 south, 10 east, 11 west
following  output  1  1 once a wall has been acquired
stuck  output  1  sticky stuck flag
removed_count  output  CNT_W  number of accepted REMOVE commands, saturating

Behaviour:
- Reset values (reset low, asynchronous): state IDLE, cmd_valid 0, cmd 00, orientation 00 (north), following 0, stuck 0, removed_count 0, turn counter 0, just_turned_left 0.
- States: IDLE, WAIT_SENS, ISSUE, STUCK.
- IDLE: cmd_valid 0; start=1 -> WAIT_SENS next cycle. start is ignored in all other states.
- WAIT_SENS: cmd_valid 0; on sensors_valid=1, sample head/left/under, compute cmd, register it, go to ISSUE. cmd_valid rises the cycle after sensors_valid (1-cycle latency).
- Decision priority, evaluated on sampled values:
  1. under=1 -> REMOVE.
  2. following=0: head=0 -> FORWARD; head=1 -> TURN_RIGHT, and following is set on that command's acceptance.
  3. following=1 and left=0 and just_turned_left=0 -> TURN_LEFT.
  4. following=1, otherwise: head=0 -> FORWARD; head=1 -> TURN_RIGHT.
- ISSUE: cmd_valid=1; cmd held stable until cmd_ready=1. The handshake completes in the cycle cmd_valid and cmd_ready are both 1. Then:
  - Return to WAIT_SENS. sensors_valid in the handshake cycle is ignored; a new sensors_valid is required.
  - FORWARD: clear turn counter, clear just_turned_left.
  - TURN_LEFT: rotate orientation north->west->south->east->north; set just_turned_left; turn counter unchanged.
  - TURN_RIGHT: rotate orientation north->east->south->west->north; increment turn counter. If the counter reaches MAX_TURNS, go to STUCK instead of WAIT_SENS.
  - REMOVE: removed_count+1, saturating at 2^CNT_W-1; orientation, turn counter and flags unchanged.
- Orientation and counters update only on accepted commands; a pending unaccepted command has no effect.
- STUCK: terminal; stuck=1, cmd_valid=0; only reset exits.
- Reset asserted mid-handshake (cmd_valid=1): all state returns to reset values immediately; the command is dropped with no counter or orientation update.
- cmd_ready while cmd_valid=0 is ignored.

Test Plan:
- Reset then start, sensors {head=0,left=0,under=0} x3 with cmd_ready=1 -> three FORWARD commands; orientation 00; following 0; cmd_valid rises exactly 1 cycle after each sensors_valid.
- Not following, sensors head=1 -> TURN_RIGHT, orientation 00->10 (east), following=1. Next sensors left=0 -> TURN_LEFT, orientation back to 00. Next left=0,head=0 -> FORWARD, not TURN_LEFT (just_turned_left suppresses it).
- under=1 with head=1,left=0 -> REMOVE; removed_count 0->1; orientation unchanged. With CNT_W=2, five REMOVEs -> removed_count saturates at 3.
- Following, four consecutive sensors {head=1,left=1} -> four TURN_RIGHT; orientation returns to 00; after the 4th acceptance stuck=1, cmd_valid=0 permanently; further sensors_valid and start are ignored.
- Backpressure: cmd_ready held 0 for 5 cycles -> cmd_valid stays 1, cmd stable, orientation unchanged. cmd_ready=1 -> single update. sensors_valid pulsed during the wait has no effect.
- Reset pulled low while cmd_valid=1 with TURN_RIGHT pending -> all outputs at reset values asynchronously (before the next clock edge), orientation 00, no rotation applied.
